// File: rtl/regfile_read_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_arb_pkg
// Description : Shared types and constants for the register-file read-port
//               arbiter: FSM state encoding, default index/data widths and
//               the requester-ID width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_arb_pkg;

    // Default register index and data widths of the 16x16 register file.
    localparam int C_AW = 4;
    localparam int C_DW = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        RESP   = 2'd2
    } state_t;

    // Requester-ID width; never zero so a single-bit ID field always exists.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_read_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin selector. Searches valid[] starting
//               at ptr and moving upward with wrap; the first set bit wins.
// Ports       : valid     in  NREQ  request vector
//               ptr       in  IDW   search start index
//               grant     out NREQ  one-hot winner (zero when nothing valid)
//               idx       out IDW   binary index of the winner
//               any_valid out 1     at least one request present
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick
    import regfile_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = id_width(NREQ)
) (
    input  logic [NREQ-1:0] valid,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  idx,
    output logic            any_valid
);

    always_comb begin : p_pick
        // One extra bit so ptr+offset never overflows before the wrap.
        logic [IDW:0] w_pos;
        logic         w_found;
        grant   = '0;
        idx     = '0;
        w_found = 1'b0;
        w_pos   = '0;
        for (int off = 0; off < NREQ; off++) begin
            w_pos = {1'b0, ptr} + (IDW+1)'(off);
            if (w_pos >= (IDW+1)'(NREQ)) begin
                w_pos = w_pos - (IDW+1)'(NREQ);
            end
            if (!w_found && valid[w_pos[IDW-1:0]]) begin
                w_found                = 1'b1;
                grant[w_pos[IDW-1:0]]  = 1'b1;
                idx                    = w_pos[IDW-1:0];
            end
        end
        any_valid = w_found;
    end

endmodule
`default_nettype wire

// File: rtl/regfile_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : regfile_read_arbiter
// Description : Round-robin arbiter sharing one read port of the register
//               file among NREQ requesters. One read in flight at a time:
//               grant (IDLE/RESP) -> LOOKUP (drive index, capture data) ->
//               RESP (hold response until rsp_ready).
//               Build option REGFILE_ARB_WR_BYPASS_EN: a same-cycle write to
//               the looked-up register is forwarded into the response.
// Ports       : clk, rst_n                 clock, async active-low reset
//               req_valid/req_reg/req_ready  per-requester request channel
//               rf_rd_reg/rf_rd_en/rf_rd_data  register file read port
//               wr_en/wr_reg/wr_data         register file write snoop
//               rsp_valid/rsp_id/rsp_data/rsp_ready  response channel
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_read_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int AW   = C_AW,
    parameter int DW   = C_DW,
    parameter int IDW  = id_width(NREQ)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NREQ-1:0]  req_valid,
    input  logic [NREQ*AW-1:0] req_reg,
    output logic [NREQ-1:0]  req_ready,
    output logic [AW-1:0]    rf_rd_reg,
    output logic             rf_rd_en,
    input  logic [DW-1:0]    rf_rd_data,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_reg,
    input  logic [DW-1:0]    wr_data,
    output logic             rsp_valid,
    output logic [IDW-1:0]   rsp_id,
    output logic [DW-1:0]    rsp_data,
    input  logic             rsp_ready
);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [IDW-1:0]  r_ptr;
    logic [IDW-1:0]  r_id;
    logic [AW-1:0]   r_idx;
    logic [DW-1:0]   r_rsp_data;

    logic [NREQ-1:0] w_pick_grant;
    logic [IDW-1:0]  w_pick_idx;
    logic            w_any_valid;
    logic [AW-1:0]   w_pick_reg;
    logic            w_grant_ok;
    logic            w_accept;
    logic [DW-1:0]   w_rd_value;

    rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .valid     (req_valid),
        .ptr       (r_ptr),
        .grant     (w_pick_grant),
        .idx       (w_pick_idx),
        .any_valid (w_any_valid)
    );

    // A new grant is allowed when nothing is in flight, or when the pending
    // response is being consumed this very cycle.
    assign w_grant_ok = (r_state == IDLE) || ((r_state == RESP) && rsp_ready);
    assign w_accept   = w_grant_ok && w_any_valid;

    // rst_n gating keeps req_ready low while reset is held even if
    // requesters are already asserting req_valid.
    assign req_ready  = (rst_n && w_grant_ok) ? w_pick_grant : '0;

    assign rf_rd_en   = (r_state == LOOKUP);
    assign rf_rd_reg  = rf_rd_en ? r_idx : '0;
    assign rsp_valid  = (r_state == RESP);
    assign rsp_id     = r_id;
    assign rsp_data   = r_rsp_data;

    // Register index of the winning requester.
    always_comb begin
        w_pick_reg = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_pick_idx == IDW'(i)) begin
                w_pick_reg = req_reg[i*AW +: AW];
            end
        end
    end

`ifdef REGFILE_ARB_WR_BYPASS_EN
    // The register file updates at the end of the write cycle, so its read
    // data is stale here; forward the write to show the post-edge value.
    assign w_rd_value = (wr_en && (wr_reg == r_idx)) ? wr_data : rf_rd_data;
`else
    assign w_rd_value = rf_rd_data;
    logic w_unused_wr;
    assign w_unused_wr = ^{wr_en, wr_reg, wr_data};
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_nxt = LOOKUP;
            LOOKUP:  w_state_nxt = RESP;
            RESP: begin
                if (rsp_ready) begin
                    w_state_nxt = w_accept ? LOOKUP : IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_ptr      <= '0;
            r_id       <= '0;
            r_idx      <= '0;
            r_rsp_data <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_idx <= w_pick_reg;
                r_id  <= w_pick_idx;
                r_ptr <= (w_pick_idx == IDW'(NREQ-1)) ? '0 : w_pick_idx + 1'b1;
            end
            if (r_state == LOOKUP) begin
                r_rsp_data <= w_rd_value;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_read_arbiter
// Description : Self-checking bench for regfile_read_arbiter (NREQ=4):
//               directed vector table, hand-written corner sequences and a
//               randomized run against a transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_read_arbiter;

`ifdef REGFILE_ARB_WR_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [15:0] req_reg;
    logic [3:0]  req_ready;
    logic [3:0]  rf_rd_reg;
    logic        rf_rd_en;
    logic [15:0] rf_rd_data;
    logic        wr_en;
    logic [3:0]  wr_reg;
    logic [15:0] wr_data;
    logic        rsp_valid;
    logic [1:0]  rsp_id;
    logic [15:0] rsp_data;
    logic        rsp_ready;

    int checks = 0;
    int errors = 0;

    // Register file model: combinational read, write at the clock edge.
    logic [15:0] rf [16];
    always @(posedge clk) if (wr_en) rf[wr_reg] <= wr_data;
    assign rf_rd_data = rf[rf_rd_reg];

    regfile_read_arbiter #(.NREQ(4), .AW(4), .DW(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_reg    (req_reg),
        .req_ready  (req_ready),
        .rf_rd_reg  (rf_rd_reg),
        .rf_rd_en   (rf_rd_en),
        .rf_rd_data (rf_rd_data),
        .wr_en      (wr_en),
        .wr_reg     (wr_reg),
        .wr_data    (wr_data),
        .rsp_valid  (rsp_valid),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .rsp_ready  (rsp_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          rst;
        logic [3:0]  valid;
        logic [15:0] regs;
        bit          rdy;
        logic [3:0]  e_rr;
        bit          e_en;
        logic [3:0]  e_reg;
        bit          e_rv;
        logic [1:0]  e_id;
        logic [15:0] e_data;
        bit          chk_all;
    } vec_t;

    vec_t tbl[14];

    function automatic vec_t mk(bit rst, logic [3:0] valid, logic [15:0] regs, bit rdy,
                                logic [3:0] e_rr, bit e_en, logic [3:0] e_reg, bit e_rv,
                                logic [1:0] e_id, logic [15:0] e_data, bit chk_all);
        vec_t v;
        v.rst = rst; v.valid = valid; v.regs = regs; v.rdy = rdy;
        v.e_rr = e_rr; v.e_en = e_en; v.e_reg = e_reg; v.e_rv = e_rv;
        v.e_id = e_id; v.e_data = e_data; v.chk_all = chk_all;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b0;
        wr_en     = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic rf_write(input logic [3:0] a, input logic [15:0] d);
        wr_en = 1'b1; wr_reg = a; wr_data = d;
        step();
        wr_en = 1'b0;
    endtask

    // Random-phase model state (transaction level)
    int          mptr;
    bit          have;
    int          age;        // 1 = lookup cycle, 2 = response presented
    int          m_id;
    logic [3:0]  m_reg;
    logic [15:0] m_data;
    bit   [3:0]  v;
    logic [3:0]  r [4];
    int          pick;
    bit          allowed;

    initial begin
        rst_n = 1'b0; req_valid = '0; req_reg = '0; rsp_ready = 1'b0;
        wr_en = 1'b0; wr_reg = '0; wr_data = '0;
        for (int i = 0; i < 16; i++) begin
            rf_write(4'(i), (i == 9) ? 16'hBEEF : (i == 3) ? 16'h0000 : 16'hA000 + 16'(i));
        end

        // ---------------- directed vector table ----------------
        // single request: requester 2, reg 9
        tbl[0]  = mk(1, 4'b0000, 16'h0000, 1, 4'b0000, 0, 4'h0, 0, 2'd0, 16'h0000, 1);
        tbl[1]  = mk(0, 4'b0100, 16'h0900, 1, 4'b0100, 0, 4'h0, 0, 2'd0, 16'h0000, 0);
        tbl[2]  = mk(0, 4'b0000, 16'h0000, 1, 4'b0000, 1, 4'h9, 0, 2'd0, 16'h0000, 0);
        tbl[3]  = mk(0, 4'b0000, 16'h0000, 1, 4'b0000, 0, 4'h0, 1, 2'd2, 16'hBEEF, 0);
        // round-robin: all valid, regs 4..7, grants 0,1,2,3,0
        tbl[4]  = mk(1, 4'b1111, 16'h7654, 1, 4'b0001, 0, 4'h0, 0, 2'd0, 16'h0000, 1);
        tbl[5]  = mk(0, 4'b1111, 16'h7654, 1, 4'b0000, 1, 4'h4, 0, 2'd0, 16'h0000, 0);
        tbl[6]  = mk(0, 4'b1111, 16'h7654, 1, 4'b0010, 0, 4'h0, 1, 2'd0, 16'hA004, 0);
        tbl[7]  = mk(0, 4'b1111, 16'h7654, 1, 4'b0000, 1, 4'h5, 0, 2'd0, 16'h0000, 0);
        tbl[8]  = mk(0, 4'b1111, 16'h7654, 1, 4'b0100, 0, 4'h0, 1, 2'd1, 16'hA005, 0);
        tbl[9]  = mk(0, 4'b1111, 16'h7654, 1, 4'b0000, 1, 4'h6, 0, 2'd0, 16'h0000, 0);
        tbl[10] = mk(0, 4'b1111, 16'h7654, 1, 4'b1000, 0, 4'h0, 1, 2'd2, 16'hA006, 0);
        tbl[11] = mk(0, 4'b1111, 16'h7654, 1, 4'b0000, 1, 4'h7, 0, 2'd0, 16'h0000, 0);
        tbl[12] = mk(0, 4'b1111, 16'h7654, 1, 4'b0001, 0, 4'h0, 1, 2'd3, 16'hA007, 0);
        tbl[13] = mk(0, 4'b1111, 16'h7654, 1, 4'b0000, 1, 4'h4, 0, 2'd0, 16'h0000, 0);

        for (int t = 0; t < 14; t++) begin
            if (tbl[t].rst) do_reset();
            req_valid = tbl[t].valid;
            req_reg   = tbl[t].regs;
            rsp_ready = tbl[t].rdy;
            wr_en     = 1'b0;
            #2;
            chk($sformatf("tbl%0d req_ready", t), 32'(req_ready), 32'(tbl[t].e_rr));
            chk($sformatf("tbl%0d rf_rd_en", t), 32'(rf_rd_en), 32'(tbl[t].e_en));
            chk($sformatf("tbl%0d rsp_valid", t), 32'(rsp_valid), 32'(tbl[t].e_rv));
            if (tbl[t].e_en || tbl[t].chk_all)
                chk($sformatf("tbl%0d rf_rd_reg", t), 32'(rf_rd_reg), 32'(tbl[t].e_reg));
            if (tbl[t].e_rv || tbl[t].chk_all) begin
                chk($sformatf("tbl%0d rsp_id", t), 32'(rsp_id), 32'(tbl[t].e_id));
                chk($sformatf("tbl%0d rsp_data", t), 32'(rsp_data), 32'(tbl[t].e_data));
            end
            step();
        end

        // ---------------- back-pressure ----------------
        do_reset();
        req_valid = 4'b0001; req_reg = 16'h0001; rsp_ready = 1'b0;
        #2; chk("bp grant0", 32'(req_ready), 32'h1);
        step();
        req_valid = 4'b0000;
        #2; chk("bp lookup reg", 32'(rf_rd_reg), 32'h1);
        step();
        req_valid = 4'b0010; req_reg = 16'h00B0;
        for (int k = 0; k < 5; k++) begin
            #2;
            chk($sformatf("bp%0d rsp_valid", k), 32'(rsp_valid), 32'h1);
            chk($sformatf("bp%0d rsp_id", k), 32'(rsp_id), 32'h0);
            chk($sformatf("bp%0d rsp_data", k), 32'(rsp_data), 32'hA001);
            chk($sformatf("bp%0d req_ready", k), 32'(req_ready), 32'h0);
            step();
        end
        rsp_ready = 1'b1;
        #2;
        chk("bp same-cycle grant", 32'(req_ready), 32'h2);
        chk("bp rsp_valid at handshake", 32'(rsp_valid), 32'h1);
        step();
        req_valid = 4'b0000;
        #2;
        chk("bp straight to lookup", 32'(rf_rd_en), 32'h1);
        chk("bp lookup reg B", 32'(rf_rd_reg), 32'hB);
        step();
        #2;
        chk("bp second rsp_id", 32'(rsp_id), 32'h1);
        chk("bp second rsp_data", 32'(rsp_data), 32'hA00B);
        step();

        // ---------------- write bypass ----------------
        do_reset();
        rsp_ready = 1'b1; req_valid = 4'b0001; req_reg = 16'h0003;
        #2; chk("byp grant", 32'(req_ready), 32'h1);
        step();
        req_valid = 4'b0000; wr_en = 1'b1; wr_reg = 4'h3; wr_data = 16'h1234;
        #2; chk("byp lookup", 32'(rf_rd_en), 32'h1);
        step();
        wr_en = 1'b0;
        #2; chk("byp rsp_data", 32'(rsp_data), BYP ? 32'h1234 : 32'h0000);
        step();

        // ---------------- reset mid-operation ----------------
        do_reset();
        rsp_ready = 1'b1; req_valid = 4'b0001; req_reg = 16'h0005;
        #2;
        step();
        req_valid = 4'b0000;
        #1; chk("rst in lookup", 32'(rf_rd_en), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("rst req_ready", 32'(req_ready), 32'h0);
        chk("rst rf_rd_en", 32'(rf_rd_en), 32'h0);
        chk("rst rf_rd_reg", 32'(rf_rd_reg), 32'h0);
        chk("rst rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst rsp_id", 32'(rsp_id), 32'h0);
        chk("rst rsp_data", 32'(rsp_data), 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            #2; chk($sformatf("rst no rsp %0d", k), 32'(rsp_valid), 32'h0);
            step();
        end
        req_valid = 4'b1010; req_reg = 16'h0000;
        #2; chk("rst first grant", 32'(req_ready), 32'h2);
        step();

        // ---------------- randomized vs. reference model ----------------
        do_reset();
        mptr = 0; have = 1'b0; age = 0; v = '0;
        for (int i = 0; i < 4; i++) r[i] = '0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            for (int i = 0; i < 4; i++) begin
                if (!v[i] && ($urandom % 2 == 0)) begin
                    v[i] = 1'b1;
                    r[i] = 4'($urandom);
                end
            end
            req_valid = v;
            req_reg   = {r[3], r[2], r[1], r[0]};
            rsp_ready = ($urandom % 10) < 7;
            wr_en     = ($urandom % 3) == 0;
            wr_reg    = 4'($urandom);
            wr_data   = 16'($urandom);
            #2;
            allowed = !have || (age == 2 && rsp_ready);
            pick = -1;
            if (allowed) begin
                for (int k = 0; k < 4; k++) begin
                    if (pick < 0 && v[(mptr + k) % 4]) pick = (mptr + k) % 4;
                end
            end
            chk("rnd req_ready", 32'(req_ready), (pick >= 0) ? (32'h1 << pick) : 32'h0);
            chk("rnd rsp_valid", 32'(rsp_valid), 32'(have && age == 2));
            if (have && age == 2) begin
                chk("rnd rsp_id", 32'(rsp_id), 32'(m_id));
                chk("rnd rsp_data", 32'(rsp_data), 32'(m_data));
            end
            chk("rnd rf_rd_en", 32'(rf_rd_en), 32'(have && age == 1));
            if (have && age == 1) begin
                chk("rnd rf_rd_reg", 32'(rf_rd_reg), 32'(m_reg));
                m_data = (BYP && wr_en && wr_reg == m_reg) ? wr_data : rf[m_reg];
            end
            if (have && age == 2 && rsp_ready) have = 1'b0;
            else if (have) age = 2;
            if (pick >= 0) begin
                have  = 1'b1;
                age   = 1;
                m_id  = pick;
                m_reg = r[pick];
                mptr  = (pick + 1) % 4;
                if ($urandom % 2 == 0) v[pick] = 1'b0;
                else r[pick] = 4'($urandom);
            end
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
